// File: rtl/i2c_master_byte_ctrl.sv
// rtl/i2c_master_byte_ctrl.sv - byte-level I2C master: START/repeated START, one byte write or read, STOP
// Open-drain bus via output enables; every bus phase is four quarters of CLK_DIV cycles.
module i2c_master_byte_ctrl #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_write,
  input  logic       cmd_read,
  input  logic       cmd_ack_out,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       rsp_valid,
  output logic       rsp_ack,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);
  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_ACK, S_STOP, S_DONE} state_t;

  state_t        state, state_n;
  logic [QW-1:0] qcnt;
  logic [1:0]    quarter;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          c_start, c_stop, c_write, c_read, c_ack_out;
  logic          scl_hold;
  logic          active, stall, q_end, sample, phase_done, has_data, last, accept;

  // Bus drive per phase and quarter; outside a phase SCL keeps whatever level the last phase left.
  always_comb begin
    scl_oe = scl_hold;
    sda_oe = 1'b0;
    case (state)
      S_START: begin
        scl_oe = (quarter == 2'd0) ? scl_hold : (quarter == 2'd3);
        sda_oe = quarter[1];
      end
      S_DATA: begin
        scl_oe = (quarter == 2'd0) || (quarter == 2'd3);
        sda_oe = c_write & ~shreg[7];
      end
      S_ACK: begin
        scl_oe = (quarter == 2'd0) || (quarter == 2'd3);
        sda_oe = c_read & ~c_ack_out;
      end
      S_STOP: begin
        scl_oe = (quarter == 2'd0);
        sda_oe = (quarter != 2'd3);
      end
      default: ;
    endcase
  end

  always_comb begin
    active     = (state == S_START) || (state == S_DATA) || (state == S_ACK) || (state == S_STOP);
    stall      = active && !scl_oe && !scl_i;
    q_end      = active && !stall && (qcnt == QLAST);
    sample     = q_end && (quarter == 2'd2);
    phase_done = q_end && (quarter == 2'd3);
    has_data   = c_write || c_read;
    state_n    = state;
    last       = 1'b0;
    case (state)
      S_START: if (phase_done) begin
        if (has_data)    state_n = S_DATA;
        else if (c_stop) state_n = S_STOP;
        else begin
          state_n = S_IDLE;
          last    = 1'b1;
        end
      end
      S_DATA: if (phase_done && bit_cnt == 3'd0) state_n = S_ACK;
      S_ACK: if (phase_done) begin
        if (c_stop) state_n = S_STOP;
        else begin
          state_n = S_IDLE;
          last    = 1'b1;
        end
      end
      S_STOP: if (phase_done) begin
        state_n = S_IDLE;
        last    = 1'b1;
      end
      S_DONE: begin
        state_n = S_IDLE;
        last    = 1'b1;
      end
      default: ;
    endcase
    rsp_valid = last;
    cmd_ready = (state == S_IDLE) || last;
    accept    = cmd_valid && cmd_ready;
    // A new command may be taken in the completion cycle itself.
    if (accept) begin
      if (cmd_start)                  state_n = S_START;
      else if (cmd_write || cmd_read) state_n = S_DATA;
      else if (cmd_stop)              state_n = S_STOP;
      else                            state_n = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      quarter   <= 2'd0;
      bit_cnt   <= 3'd7;
      shreg     <= 8'h00;
      c_start   <= 1'b0;
      c_stop    <= 1'b0;
      c_write   <= 1'b0;
      c_read    <= 1'b0;
      c_ack_out <= 1'b1;
      rd_data   <= 8'h00;
      rsp_ack   <= 1'b1;
      busy      <= 1'b0;
      scl_hold  <= 1'b0;
    end else begin
      state <= state_n;
      if (active) scl_hold <= scl_oe;
      if (active && !stall) begin
        if (qcnt == QLAST) begin
          qcnt    <= '0;
          quarter <= quarter + 2'd1;
        end else begin
          qcnt <= qcnt + 1'b1;
        end
      end
      if (sample && state == S_DATA && c_read)  shreg   <= {shreg[6:0], sda_i};
      if (sample && state == S_ACK && c_write)  rsp_ack <= sda_i;
      if (phase_done) begin
        case (state)
          S_START: busy <= 1'b1;
          S_DATA: begin
            bit_cnt <= bit_cnt - 3'd1;
            if (c_write) shreg <= {shreg[6:0], 1'b0};
            if (c_read && bit_cnt == 3'd0) rd_data <= shreg;
          end
          S_STOP: busy <= 1'b0;
          default: ;
        endcase
      end
      if (accept) begin
        c_start   <= cmd_start;
        c_stop    <= cmd_stop;
        c_write   <= cmd_write;
        c_read    <= cmd_read && !cmd_write;
        c_ack_out <= cmd_ack_out;
        shreg     <= wr_data;
        qcnt      <= '0;
        quarter   <= 2'd0;
        bit_cnt   <= 3'd7;
        rsp_ack   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// tb/tb_i2c_master_byte_ctrl.sv - table-driven scoreboard bench with a behavioural I2C slave at 0x10
module tb_i2c_master_byte_ctrl;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, cmd_ready, cmd_start, cmd_stop, cmd_write, cmd_read, cmd_ack_out;
  logic [7:0] wr_data, rd_data;
  logic       rsp_valid, rsp_ack, busy, scl_oe, sda_oe;
  logic       force_scl, s_sda_oe;
  logic       scl_bus, sda_bus;

  always #5 clk = ~clk;

  assign scl_bus = !(scl_oe || force_scl);
  assign sda_bus = !(sda_oe || s_sda_oe);

  i2c_master_byte_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_write(cmd_write), .cmd_read(cmd_read),
    .cmd_ack_out(cmd_ack_out), .wr_data(wr_data), .rd_data(rd_data), .rsp_valid(rsp_valid),
    .rsp_ack(rsp_ack), .busy(busy), .scl_i(scl_bus), .sda_i(sda_bus), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  // Slave: first byte after a write address sets the pointer, later bytes write mem[ptr]; reads return mem[ptr].
  typedef enum logic [1:0] {SL_IDLE, SL_RX, SL_TX} sl_t;
  sl_t        sl_st;
  logic [3:0] sl_cnt;
  logic       sl_wait, sl_addr, sl_ptr_ph, sl_nack, p_scl, p_sda;
  logic [7:0] sl_sr, sl_tx, sl_ptr;
  logic [7:0] mem [256];

  always @(posedge clk) begin
    p_scl <= scl_bus;
    p_sda <= sda_bus;
    if (!rst_n) begin
      sl_st <= SL_IDLE; s_sda_oe <= 1'b0; sl_cnt <= 4'd0; sl_wait <= 1'b0;
      sl_ptr <= 8'h00; sl_ptr_ph <= 1'b0; sl_addr <= 1'b0; sl_nack <= 1'b0;
    end else if (p_scl && scl_bus && p_sda && !sda_bus) begin
      sl_st <= SL_RX; sl_addr <= 1'b1; sl_cnt <= 4'd0; sl_wait <= 1'b1; s_sda_oe <= 1'b0;
    end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
      sl_st <= SL_IDLE; s_sda_oe <= 1'b0;
    end else if (sl_st != SL_IDLE && !p_scl && scl_bus) begin
      if (sl_cnt < 4'd8 && sl_st == SL_RX) sl_sr <= {sl_sr[6:0], sda_bus};
      if (sl_cnt == 4'd8 && sl_st == SL_TX) sl_nack <= sda_bus;
    end else if (sl_st != SL_IDLE && p_scl && !scl_bus) begin
      if (sl_wait) sl_wait <= 1'b0;
      else if (sl_cnt == 4'd7) begin
        sl_cnt <= 4'd8;
        if (sl_st == SL_TX) s_sda_oe <= 1'b0;
        else if (sl_addr) s_sda_oe <= (sl_sr[7:1] == 7'h10);
        else begin
          s_sda_oe <= 1'b1;
          if (sl_ptr_ph) sl_ptr <= sl_sr;
          else mem[sl_ptr] <= sl_sr;
          sl_ptr_ph <= 1'b0;
        end
      end else if (sl_cnt == 4'd8) begin
        sl_cnt   <= 4'd0;
        s_sda_oe <= 1'b0;
        if (sl_st == SL_TX) begin
          if (sl_nack) sl_st <= SL_IDLE;
          else begin sl_tx <= mem[sl_ptr]; s_sda_oe <= !mem[sl_ptr][7]; end
        end else if (sl_addr) begin
          sl_addr <= 1'b0;
          if (sl_sr[7:1] != 7'h10) sl_st <= SL_IDLE;
          else if (sl_sr[0]) begin sl_st <= SL_TX; sl_tx <= mem[sl_ptr]; s_sda_oe <= !mem[sl_ptr][7]; end
          else sl_ptr_ph <= 1'b1;
        end
      end else begin
        sl_cnt <= sl_cnt + 4'd1;
        if (sl_st == SL_TX) begin sl_tx <= {sl_tx[6:0], 1'b0}; s_sda_oe <= !sl_tx[6]; end
      end
    end
  end

  typedef struct {
    logic st, sp, wr, rd, ao;
    logic [7:0] wd;
    logic e_ack;
    logic [7:0] e_rd;
    logic e_busy, e_scl;
  } vec_t;
  typedef struct { int due; logic ack; logic [7:0] rd; } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   total = 0, bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      chk("rsp_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        got_e = sb.pop_front();
        chk("rsp_cycle", cyc, got_e.due);
        chk("rsp_ack", int'(rsp_ack), int'(got_e.ack));
        chk("rd_data", int'(rd_data), int'(got_e.rd));
      end
    end
  end

  task automatic run_cmd(input vec_t v, input int extra);
    int n, lat;
    exp_t e;
    bit seen, rdy_ok;
    n   = (v.st ? 1 : 0) + ((v.wr || v.rd) ? 9 : 0) + (v.sp ? 1 : 0);
    lat = (n == 0) ? 1 : n * 4 * D + extra;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = v.st; cmd_stop = v.sp; cmd_write = v.wr;
    cmd_read = v.rd; cmd_ack_out = v.ao; wr_data = v.wd;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    e.due = cyc + lat; e.ack = v.e_ack; e.rd = v.e_rd;
    sb.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    seen = 1'b0; rdy_ok = 1'b1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (cmd_ready !== rsp_valid) rdy_ok = 1'b0;
      seen = rsp_valid;
    end
    chk("rsp_seen", int'(seen), 1);
    chk("ready_low_until_rsp", int'(rdy_ok), 1);
    if (!seen) sb.delete();
    @(negedge clk);
    chk("busy_after", int'(busy), int'(v.e_busy));
    chk("idle_scl_oe", int'(scl_oe), int'(v.e_scl));
    chk("idle_sda_oe", int'(sda_oe), 0);
  endtask

  task automatic wait_release(input int nth, output bit ok);
    int cnt;
    logic p;
    cnt = 0;
    p = scl_oe;
    for (int i = 0; i < 3000 && cnt < nth; i++) begin
      @(negedge clk);
      if (p && !scl_oe) cnt++;
      p = scl_oe;
    end
    ok = (cnt == nth);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  vec_t vt[16];
  bit   ok, saw;

  initial begin
    vt[0]  = '{1,0,1,0,0,8'h20, 0,8'h00, 1,1};
    vt[1]  = '{0,0,1,0,0,8'h00, 0,8'h00, 1,1};
    vt[2]  = '{0,1,1,0,0,8'h77, 0,8'h00, 0,0};
    vt[3]  = '{0,0,0,0,0,8'h00, 1,8'h00, 0,0};
    vt[4]  = '{1,0,1,0,0,8'h22, 1,8'h00, 1,1};
    vt[5]  = '{0,1,0,0,0,8'h00, 1,8'h00, 0,0};
    vt[6]  = '{1,0,1,0,0,8'h20, 0,8'h00, 1,1};
    vt[7]  = '{0,0,1,0,0,8'h03, 0,8'h00, 1,1};
    vt[8]  = '{0,1,1,0,0,8'h5A, 0,8'h00, 0,0};
    vt[9]  = '{1,0,1,0,0,8'h21, 0,8'h00, 1,1};
    vt[10] = '{0,1,0,1,1,8'h00, 1,8'h5A, 0,0};
    vt[11] = '{1,0,1,1,0,8'h20, 0,8'h5A, 1,1};
    vt[12] = '{0,0,1,0,0,8'h00, 0,8'h5A, 1,1};
    vt[13] = '{1,0,1,0,0,8'h21, 0,8'h5A, 1,1};
    vt[14] = '{0,0,0,1,0,8'h00, 1,8'h77, 1,1};
    vt[15] = '{0,1,0,1,1,8'h00, 1,8'h77, 0,0};

    rst_n = 1'b0; force_scl = 1'b0;
    cmd_valid = 1'b1; cmd_start = 1'b1; cmd_stop = 1'b0; cmd_write = 1'b1;
    cmd_read = 1'b0; cmd_ack_out = 1'b1; wr_data = 8'h20;
    repeat (5) @(negedge clk);
    chk("reset_scl_oe", int'(scl_oe), 0);
    chk("reset_sda_oe", int'(sda_oe), 0);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_ack", int'(rsp_ack), 1);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_busy", int'(busy), 0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 16; i++) run_cmd(vt[i], 0);

    // SCL held low externally for 20 cycles in the release quarter of bit 5.
    run_cmd('{1,0,1,0,0,8'h20, 0,8'h77, 1,1}, 0);
    run_cmd('{0,0,1,0,0,8'h05, 0,8'h77, 1,1}, 0);
    fork
      run_cmd('{0,1,1,0,0,8'hC3, 0,8'h77, 0,0}, 20);
      begin
        wait_release(3, ok);
        chk("stretch_armed", int'(ok), 1);
        force_scl = 1'b1;
        repeat (20) @(negedge clk);
        force_scl = 1'b0;
      end
    join
    run_cmd('{1,0,1,0,0,8'h21, 0,8'h77, 1,1}, 0);
    run_cmd('{0,1,0,1,1,8'h00, 1,8'hC3, 0,0}, 0);

    // Reset during bit 4 of a write: bus released at once, no response.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = 1'b1; cmd_stop = 1'b0; cmd_write = 1'b1;
    cmd_read = 1'b0; wr_data = 8'h20;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_release(4, ok);
    chk("reset_armed", int'(ok), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_scl_oe", int'(scl_oe), 0);
    chk("midrst_sda_oe", int'(sda_oe), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rd_data", int'(rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    chk("no_rsp_after_reset", int'(saw), 0);
    run_cmd('{1,1,1,0,0,8'h20, 0,8'h00, 0,0}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
